parallel_stream_mux: RTL and testbench

//  Drains NCHAN per-camera pixel FIFOs (rclk side, 1-cycle read latency) in lock-step groups and

---
 rtl/parallel_stream_mux.sv | 261 ++++++++++++++++++++++++++
 tb/tb_parallel_stream_mux.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_stream_mux.sv
// parallel_stream_mux
//
// Drains NCHAN per-camera pixel FIFOs (1-cycle read latency) in lock-step groups
// and serialises them onto a narrow source-synchronous debug bus. A group is one
// DATA_W word from every channel enabled in the latched mask, lowest channel first,
// least-significant beat first. Back-to-back groups keep bus_valid_o high.
//
// Optional feature macro: PARALLEL_STREAM_MUX_PARITY_EN adds bus_parity_o, the
// registered XOR of {bus_data_o, bus_sof_o, bus_chan_o} (0 while idle).
//
// Ports
//   clock, reset           system clock, asynchronous active-high reset
//   enable_i               permit new groups to start
//   chan_mask_i            channels taking part in a group, sampled at group start
//   fifo_empty_i           per-channel FIFO empty
//   fifo_almost_empty_i    per-channel FIFO almost-empty
//   fifo_data_i            per-channel read data, valid one cycle after fifo_rd_o
//   fifo_sof_i             per-channel start-of-frame flag, same timing as data
//   fifo_rd_o              per-channel single-cycle read strobe
//   bus_data_o             beat data
//   bus_clk_o              bus clock, receiver samples on its rising edge
//   bus_valid_o            beat valid
//   bus_sof_o              sof flag of the word on the bus
//   bus_chan_o             channel of the word on the bus
//   bus_parity_o           parity (only with PARALLEL_STREAM_MUX_PARITY_EN)
module parallel_stream_mux #(
    parameter int NCHAN   = 2,
    parameter int DATA_W  = 8,
    parameter int BUS_W   = 4,
    parameter int CLK_DIV = 8
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     enable_i,
    input  logic [NCHAN-1:0]                         chan_mask_i,
    input  logic [NCHAN-1:0]                         fifo_empty_i,
    input  logic [NCHAN-1:0]                         fifo_almost_empty_i,
    input  logic [NCHAN-1:0][DATA_W-1:0]             fifo_data_i,
    input  logic [NCHAN-1:0]                         fifo_sof_i,
    output logic [NCHAN-1:0]                         fifo_rd_o,
    output logic [BUS_W-1:0]                         bus_data_o,
    output logic                                     bus_clk_o,
    output logic                                     bus_valid_o,
    output logic                                     bus_sof_o,
`ifdef PARALLEL_STREAM_MUX_PARITY_EN
    output logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0] bus_chan_o,
    output logic                                     bus_parity_o
`else
    output logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0] bus_chan_o
`endif
);

    localparam int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int BEATS  = DATA_W / BUS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(CLK_DIV - 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    generate
        if (NCHAN < 1 || NCHAN > 8 || BUS_W < 1 || DATA_W < BUS_W || (DATA_W % BUS_W) != 0 ||
            CLK_DIV < 4 || (CLK_DIV & (CLK_DIV - 1)) != 0) begin : g_bad_cfg
            $error("parallel_stream_mux: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t                         state_r, state_n;
    logic [CNT_W-1:0]               cnt_r;
    logic [NCHAN-1:0]               active_mask_r;
    logic [NCHAN-1:0][DATA_W-1:0]   hold_r, hold_n;
    logic [NCHAN-1:0]               hold_sof_r, hold_sof_n;
    logic [CHAN_W-1:0]              chan_r, chan_n;
    logic [BEAT_W-1:0]              beat_r, beat_n;
    logic [BUS_W-1:0]               bus_data_n;
    logic                           ready_s, last_s;
    logic                           latch_s, capture_s, advance_s;
    logic [NCHAN-1:0]               rd_s;

    // Lowest set bit of mask at or above index from (0 when none).
    function automatic logic [CHAN_W-1:0] first_chan(input logic [NCHAN-1:0] mask, input int from);
        first_chan = {CHAN_W{1'b0}};
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) begin
                first_chan = CHAN_W'(i);
            end
        end
    endfunction

    // True when mask has an active channel above ch.
    function automatic logic has_above(input logic [NCHAN-1:0] mask, input logic [CHAN_W-1:0] ch);
        has_above = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (mask[i] && (i > int'(ch))) begin
                has_above = 1'b1;
            end
        end
    endfunction

`ifdef PARALLEL_STREAM_MUX_PARITY_EN
    // Even parity: XOR over everything the receiver sees for one beat.
    function automatic logic even_parity(input logic [BUS_W+CHAN_W:0] v);
        even_parity = ^v;
    endfunction
`endif

    // Start qualifier and end-of-group detection.
    always_comb begin
        ready_s = enable_i && (|chan_mask_i) &&
                  ((chan_mask_i & (fifo_empty_i | fifo_almost_empty_i)) == {NCHAN{1'b0}});
        last_s  = (beat_r == BEAT_LAST) && !has_above(active_mask_r, chan_r);
    end

    // Next-state logic; the read decision sits one cycle before the capture edge.
    always_comb begin
        state_n   = state_r;
        rd_s      = {NCHAN{1'b0}};
        latch_s   = 1'b0;
        capture_s = 1'b0;
        advance_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cnt_r == CNT_PRE && ready_s) begin
                    rd_s    = chan_mask_i;
                    latch_s = 1'b1;
                    state_n = ST_PRIME;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_PRIME: begin
                // Only ever entered for the final phase, so this is the capture edge.
                capture_s = 1'b1;
                state_n   = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt_r == CNT_PRE && last_s && ready_s) begin
                    // Chain the next group; the bus registers keep the last beat meanwhile.
                    rd_s    = chan_mask_i;
                    latch_s = 1'b1;
                    state_n = ST_PRIME;
                end else if (cnt_r == CNT_LAST) begin
                    if (last_s) begin
                        state_n = ST_IDLE;
                    end else begin
                        advance_s = 1'b1;
                        state_n   = ST_BUSY;
                    end
                end else begin
                    state_n = ST_BUSY;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Hold/beat/channel pointer update and the beat selected for the next bus phase.
    always_comb begin
        hold_n     = hold_r;
        hold_sof_n = hold_sof_r;
        chan_n     = chan_r;
        beat_n     = beat_r;
        if (capture_s) begin
            for (int i = 0; i < NCHAN; i++) begin
                if (active_mask_r[i]) begin
                    hold_n[i]     = fifo_data_i[i];
                    hold_sof_n[i] = fifo_sof_i[i];
                end else begin
                    hold_n[i]     = hold_r[i];
                    hold_sof_n[i] = hold_sof_r[i];
                end
            end
            chan_n = first_chan(active_mask_r, 0);
            beat_n = {BEAT_W{1'b0}};
        end else if (advance_s) begin
            if (beat_r == BEAT_LAST) begin
                beat_n = {BEAT_W{1'b0}};
                chan_n = first_chan(active_mask_r, int'(chan_r) + 1);
            end else begin
                beat_n = beat_r + BEAT_W'(1);
            end
        end else begin
            beat_n = beat_r;
        end
        bus_data_n = hold_n[chan_n][int'(beat_n)*BUS_W +: BUS_W];
    end

    assign fifo_rd_o = rd_s;

    // Free-running bus phase counter; CLK_DIV is a power of two so it wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r     <= {CNT_W{1'b0}};
            bus_clk_o <= 1'b0;
        end else begin
            cnt_r     <= cnt_r + CNT_W'(1);
            bus_clk_o <= (cnt_r + CNT_W'(1)) >= CNT_W'(CLK_DIV / 2);
        end
    end

    // Control state, latched mask and hold registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            active_mask_r <= {NCHAN{1'b0}};
            hold_r        <= {(NCHAN*DATA_W){1'b0}};
            hold_sof_r    <= {NCHAN{1'b0}};
            chan_r        <= {CHAN_W{1'b0}};
            beat_r        <= {BEAT_W{1'b0}};
        end else begin
            state_r    <= state_n;
            hold_r     <= hold_n;
            hold_sof_r <= hold_sof_n;
            chan_r     <= chan_n;
            beat_r     <= beat_n;
            if (latch_s) begin
                active_mask_r <= chan_mask_i;
            end
        end
    end

    // Bus output registers change only on the bus_clk_o falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_valid_o  <= 1'b0;
            bus_data_o   <= {BUS_W{1'b0}};
            bus_sof_o    <= 1'b0;
            bus_chan_o   <= {CHAN_W{1'b0}};
`ifdef PARALLEL_STREAM_MUX_PARITY_EN
            bus_parity_o <= 1'b0;
`endif
        end else if (cnt_r == CNT_LAST) begin
            if (capture_s || advance_s) begin
                bus_valid_o  <= 1'b1;
                bus_data_o   <= bus_data_n;
                bus_sof_o    <= hold_sof_n[chan_n];
                bus_chan_o   <= chan_n;
`ifdef PARALLEL_STREAM_MUX_PARITY_EN
                bus_parity_o <= even_parity({bus_data_n, hold_sof_n[chan_n], chan_n});
`endif
            end else begin
                bus_valid_o  <= 1'b0;
                bus_data_o   <= {BUS_W{1'b0}};
                bus_sof_o    <= 1'b0;
                bus_chan_o   <= {CHAN_W{1'b0}};
`ifdef PARALLEL_STREAM_MUX_PARITY_EN
                bus_parity_o <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_parallel_stream_mux.sv
// Directed testbench for parallel_stream_mux (NCHAN=2, DATA_W=8, BUS_W=4, CLK_DIV=8).
// A small FIFO model answers read strobes with one-cycle latency; a per-cycle monitor
// records beats (at bus_clk_o rising), valid run lengths and read pulses.
module tb_parallel_stream_mux;

    logic             clock;
    logic             reset;
    logic             enable_i;
    logic [1:0]       chan_mask_i;
    logic [1:0]       fifo_empty_i;
    logic [1:0]       fifo_almost_empty_i;
    logic [1:0][7:0]  fifo_data_i;
    logic [1:0]       fifo_sof_i;
    logic [1:0]       fifo_rd_o;
    logic [3:0]       bus_data_o;
    logic             bus_clk_o;
    logic             bus_valid_o;
    logic             bus_sof_o;
    logic [0:0]       bus_chan_o;
`ifdef PARALLEL_STREAM_MUX_PARITY_EN
    logic             bus_parity_o;
`endif

    parallel_stream_mux #(
        .NCHAN(2), .DATA_W(8), .BUS_W(4), .CLK_DIV(8)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .enable_i            (enable_i),
        .chan_mask_i         (chan_mask_i),
        .fifo_empty_i        (fifo_empty_i),
        .fifo_almost_empty_i (fifo_almost_empty_i),
        .fifo_data_i         (fifo_data_i),
        .fifo_sof_i          (fifo_sof_i),
        .fifo_rd_o           (fifo_rd_o),
        .bus_data_o          (bus_data_o),
        .bus_clk_o           (bus_clk_o),
        .bus_valid_o         (bus_valid_o),
        .bus_sof_o           (bus_sof_o),
`ifdef PARALLEL_STREAM_MUX_PARITY_EN
        .bus_chan_o          (bus_chan_o),
        .bus_parity_o        (bus_parity_o)
`else
        .bus_chan_o          (bus_chan_o)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_err = 0;

    // FIFO model state: {sof, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int         ae_lvl;

    // Monitor state
    int         cyc, valid_cnt, run, max_run, first_valid_t, rd_first_t;
    logic       first_valid_clk, prev_clk;
    int         rd_cnt[2];
    int         rd1_t[$];
    logic [7:0] beat_q[$];
    logic [7:0] exp_q[$];
    logic       clk_hist[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] eb(input logic [3:0] d, input logic c, input logic s);
        logic par;
`ifdef PARALLEL_STREAM_MUX_PARITY_EN
        par = ^{d, s, c};
`else
        par = 1'b0;
`endif
        return {par, 1'b0, s, c, d};
    endfunction

    function automatic logic [7:0] pack_obs();
        logic par;
`ifdef PARALLEL_STREAM_MUX_PARITY_EN
        par = bus_parity_o;
`else
        par = 1'b0;
`endif
        return {par, 1'b0, bus_sof_o, bus_chan_o[0], bus_data_o};
    endfunction

    task automatic update_flags();
        fifo_empty_i[0]        = (q0.size() == 0);
        fifo_empty_i[1]        = (q1.size() == 0);
        fifo_almost_empty_i[0] = (q0.size() < ae_lvl);
        fifo_almost_empty_i[1] = (q1.size() < ae_lvl);
    endtask

    task automatic mon_clear();
        valid_cnt = 0; run = 0; max_run = 0; first_valid_t = -1; rd_first_t = -1;
        first_valid_clk = 1'b0;
        rd_cnt[0] = 0; rd_cnt[1] = 0;
        rd1_t.delete(); beat_q.delete(); exp_q.delete(); clk_hist.delete();
    endtask

    // One system clock: sample at negedge, then update the FIFO model just after posedge.
    task automatic tick();
        logic [1:0] rd_seen;
        logic [8:0] w;
        @(negedge clock);
        cyc++;
        rd_seen = fifo_rd_o;
        for (int c = 0; c < 2; c++) if (rd_seen[c]) rd_cnt[c]++;
        if (rd_seen != 2'b00 && rd_first_t < 0) rd_first_t = cyc;
        if (rd_seen[1]) rd1_t.push_back(cyc);
        if (bus_valid_o) begin
            valid_cnt++;
            run++;
            if (run > max_run) max_run = run;
            if (first_valid_t < 0) begin
                first_valid_t   = cyc;
                first_valid_clk = bus_clk_o;
            end
        end else begin
            run = 0;
        end
        if (bus_clk_o && !prev_clk && bus_valid_o) beat_q.push_back(pack_obs());
        clk_hist.push_back(bus_clk_o);
        prev_clk = bus_clk_o;
        @(posedge clock);
        #1;
        if (rd_seen[0] && q0.size() > 0) begin
            w = q0.pop_front(); fifo_data_i[0] = w[7:0]; fifo_sof_i[0] = w[8];
        end
        if (rd_seen[1] && q1.size() > 0) begin
            w = q1.pop_front(); fifo_data_i[1] = w[7:0]; fifo_sof_i[1] = w[8];
        end
        update_flags();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_beats(input string tag);
        check_val({tag, "_nbeats"}, beat_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_val($sformatf("%s_beat%0d", tag, i),
                      (i < beat_q.size()) ? {24'h0, beat_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
        end
    endtask

    task automatic clear_fifos();
        enable_i = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    initial begin
        int viol, highs, waited;
        reset = 1'b1; enable_i = 1'b0; chan_mask_i = 2'b00; ae_lvl = 1;
        fifo_data_i = 16'h0; fifo_sof_i = 2'b00;
        cyc = 0; prev_clk = 1'b0;
        mon_clear();
        update_flags();
        run_cycles(3);

        // Reset state
        check_val("rst_rd", fifo_rd_o, 2'b00);
        check_val("rst_valid", bus_valid_o, 1'b0);
        check_val("rst_data", bus_data_o, 4'h0);
        check_val("rst_sof", bus_sof_o, 1'b0);
        check_val("rst_chan", bus_chan_o, 1'b0);
        check_val("rst_busclk", bus_clk_o, 1'b0);

        // Bus clock shape: 4 high / 4 low
        reset = 1'b0;
        mon_clear();
        run_cycles(16);
        viol = 0; highs = 0;
        for (int k = 0; k < 16; k++) if (clk_hist[k]) highs++;
        for (int k = 0; k < 12; k++) if (clk_hist[k+4] == clk_hist[k]) viol++;
        check_val("busclk_high_cnt", highs, 8);
        check_val("busclk_halfperiod_viol", viol, 0);

        // Test 1: both channels, A5 (sof) and 3C
        mon_clear();
        q0.push_back({1'b1, 8'hA5}); q1.push_back({1'b0, 8'h3C});
        chan_mask_i = 2'b11; enable_i = 1'b1;
        run_cycles(60);
        exp_q.push_back(eb(4'h5, 1'b0, 1'b1)); exp_q.push_back(eb(4'hA, 1'b0, 1'b1));
        exp_q.push_back(eb(4'hC, 1'b1, 1'b0)); exp_q.push_back(eb(4'h3, 1'b1, 1'b0));
        check_beats("t1");
        check_val("t1_valid_cycles", valid_cnt, 32);
        check_val("t1_max_run", max_run, 32);
        check_val("t1_rd0", rd_cnt[0], 1);
        check_val("t1_rd1", rd_cnt[1], 1);
        check_val("t1_latency", first_valid_t - rd_first_t, 2);
        check_val("t1_first_beat_busclk", first_valid_clk, 1'b0);

        // Test 2: mask 10, both ready
        clear_fifos(); tick(); mon_clear();
        q0.push_back({1'b0, 8'h11}); q1.push_back({1'b1, 8'h3C});
        chan_mask_i = 2'b10; enable_i = 1'b1;
        run_cycles(50);
        exp_q.push_back(eb(4'hC, 1'b1, 1'b1)); exp_q.push_back(eb(4'h3, 1'b1, 1'b1));
        check_beats("t2");
        check_val("t2_rd0", rd_cnt[0], 0);
        check_val("t2_rd1", rd_cnt[1], 1);
        check_val("t2_valid_cycles", valid_cnt, 16);

        // Test 3a: ch1 empty, ch0 has data
        clear_fifos(); tick(); mon_clear();
        q0.push_back({1'b0, 8'h11}); q0.push_back({1'b0, 8'h22}); q0.push_back({1'b0, 8'h33});
        chan_mask_i = 2'b11; enable_i = 1'b1;
        run_cycles(40);
        check_val("t3a_rd0", rd_cnt[0], 0);
        check_val("t3a_rd1", rd_cnt[1], 0);
        check_val("t3a_valid_cycles", valid_cnt, 0);

        // Test 3b: ch1 holds one word but is almost-empty
        enable_i = 1'b0; ae_lvl = 2; q1.push_back({1'b0, 8'h44}); tick(); mon_clear();
        enable_i = 1'b1;
        run_cycles(40);
        check_val("t3b_rd0", rd_cnt[0], 0);
        check_val("t3b_rd1", rd_cnt[1], 0);
        check_val("t3b_valid_cycles", valid_cnt, 0);

        // Test 4: three words per channel, back-to-back groups
        clear_fifos(); ae_lvl = 1; tick(); mon_clear();
        q0.push_back({1'b1, 8'h12}); q0.push_back({1'b0, 8'h34}); q0.push_back({1'b0, 8'h56});
        q1.push_back({1'b0, 8'h9A}); q1.push_back({1'b0, 8'hBC}); q1.push_back({1'b1, 8'hDE});
        chan_mask_i = 2'b11; enable_i = 1'b1;
        run_cycles(130);
        exp_q.push_back(eb(4'h2, 1'b0, 1'b1)); exp_q.push_back(eb(4'h1, 1'b0, 1'b1));
        exp_q.push_back(eb(4'hA, 1'b1, 1'b0)); exp_q.push_back(eb(4'h9, 1'b1, 1'b0));
        exp_q.push_back(eb(4'h4, 1'b0, 1'b0)); exp_q.push_back(eb(4'h3, 1'b0, 1'b0));
        exp_q.push_back(eb(4'hC, 1'b1, 1'b0)); exp_q.push_back(eb(4'hB, 1'b1, 1'b0));
        exp_q.push_back(eb(4'h6, 1'b0, 1'b0)); exp_q.push_back(eb(4'h5, 1'b0, 1'b0));
        exp_q.push_back(eb(4'hE, 1'b1, 1'b1)); exp_q.push_back(eb(4'hD, 1'b1, 1'b1));
        check_beats("t4");
        check_val("t4_valid_cycles", valid_cnt, 96);
        check_val("t4_max_run", max_run, 96);
        check_val("t4_rd0", rd_cnt[0], 3);
        check_val("t4_rd1_n", rd1_t.size(), 3);
        if (rd1_t.size() == 3) begin
            check_val("t4_rd_gap1", rd1_t[1] - rd1_t[0], 32);
            check_val("t4_rd_gap2", rd1_t[2] - rd1_t[1], 32);
        end
        check_val("t4_idle_valid", bus_valid_o, 1'b0);

        // Test 5: mask/enable change mid-group has no effect on the group
        clear_fifos(); tick(); mon_clear();
        q0.push_back({1'b1, 8'hA5}); q1.push_back({1'b0, 8'h3C});
        chan_mask_i = 2'b11; enable_i = 1'b1;
        waited = 0;
        while (rd_cnt[0] == 0 && waited < 40) begin tick(); waited++; end
        check_val("t5_start_timeout", (waited < 40), 1'b1);
        chan_mask_i = 2'b01; enable_i = 1'b0;
        run_cycles(50);
        exp_q.push_back(eb(4'h5, 1'b0, 1'b1)); exp_q.push_back(eb(4'hA, 1'b0, 1'b1));
        exp_q.push_back(eb(4'hC, 1'b1, 1'b0)); exp_q.push_back(eb(4'h3, 1'b1, 1'b0));
        check_beats("t5");

        // Test 6: reset during beat 2, then a clean group
        clear_fifos(); tick(); mon_clear();
        q0.push_back({1'b1, 8'hA5}); q1.push_back({1'b0, 8'h3C});
        chan_mask_i = 2'b11; enable_i = 1'b1;
        waited = 0;
        while (!(bus_valid_o && bus_chan_o == 1'b1) && waited < 80) begin tick(); waited++; end
        check_val("t6_beat2_timeout", (waited < 80), 1'b1);
        reset = 1'b1;
        #1;
        check_val("t6_rst_valid", bus_valid_o, 1'b0);
        check_val("t6_rst_data", bus_data_o, 4'h0);
        check_val("t6_rst_chan", bus_chan_o, 1'b0);
        check_val("t6_rst_busclk", bus_clk_o, 1'b0);
        check_val("t6_rst_rd", fifo_rd_o, 2'b00);
        run_cycles(3);
        mon_clear();
        q0.push_back({1'b0, 8'h5A}); q1.push_back({1'b1, 8'hC3});
        tick();
        reset = 1'b0;
        run_cycles(60);
        exp_q.push_back(eb(4'hA, 1'b0, 1'b0)); exp_q.push_back(eb(4'h5, 1'b0, 1'b0));
        exp_q.push_back(eb(4'h3, 1'b1, 1'b1)); exp_q.push_back(eb(4'hC, 1'b1, 1'b1));
        check_beats("t6");
        check_val("t6_rd0", rd_cnt[0], 1);
        check_val("t6_rd1", rd_cnt[1], 1);
        check_val("t6_valid_cycles", valid_cnt, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
